// File: rtl/uart_tx_fifo.sv
// Circular TX byte FIFO draining into a UART transceiver start/busy handshake.
// One byte is popped per frame; the drain FSM waits for busy to rise and fall.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_busy
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
  logic                    wr_acc, pop;

  // Fullness is judged on the registered count, so a same-edge pop never frees a slot.
  assign wr_acc = wr_en & ~full;
  assign pop    = (state == IDLE) & ~empty & ~tx_busy;
  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_data  <= '0;
    end else begin
      overflow <= wr_en & full;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        tx_data <= mem[rd_ptr];
      end
      case ({wr_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pop)      state_nxt = START;
      START:                   state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_start = (state == START);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: transceiver model, occupancy/order scoreboard
// and per-scenario tasks with inline checks.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, tx_start, tx_busy;
  logic [4:0] count;
  logic [7:0] tx_data;
  int         checks = 0, errors = 0;

  uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // Transceiver model: busy for a random frame length after each start, then loops the byte back.
  logic       busy_force = 1'b0, rx_valid;
  logic [7:0] rx_data, shift_byte;
  int         frame_cnt;
  assign tx_busy = busy_force | (frame_cnt != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 0; rx_valid <= 1'b0; rx_data <= 8'h00; shift_byte <= 8'h00;
    end else begin
      rx_valid <= 1'b0;
      if (tx_start && frame_cnt == 0) begin
        frame_cnt  <= int'($urandom_range(2, 6));
        shift_byte <= tx_data;
      end else if (frame_cnt != 0) begin
        frame_cnt <= frame_cnt - 1;
        if (frame_cnt == 1) begin rx_valid <= 1'b1; rx_data <= shift_byte; end
      end
    end
  end

  // Reference: occupancy = accepted writes - launched frames; bytes leave in acceptance order.
  int         acc, launched, viol, ovf_seen;
  logic       exp_ovf, prev_start;
  logic [7:0] exp_mem  [0:1023];
  logic [7:0] sent_log [0:1023];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 0; exp_ovf <= 1'b0;
    end else begin
      exp_ovf <= wr_en && (acc - launched) >= DEPTH;
      if (wr_en && (acc - launched) < DEPTH) begin
        exp_mem[acc % 1024] <= wr_data;
        acc <= acc + 1;
      end
    end
  end

  always @(negedge clk) begin
    int occ;
    if (!rst_n) begin
      launched = 0; prev_start = 1'b0;
    end else begin
      if (tx_start) begin
        if (tx_data !== exp_mem[launched % 1024]) begin
          viol++; $display("violation t=%0t: byte %0d sent %h expected %h", $time, launched, tx_data, exp_mem[launched % 1024]);
        end
        if (prev_start || tx_busy) begin
          viol++; $display("violation t=%0t: start while busy or back-to-back", $time);
        end
        sent_log[launched % 1024] = tx_data;
        launched++;
      end
      prev_start = tx_start;
      occ = acc - launched;
      if (occ < 0 || occ > DEPTH || count !== 5'(occ) || full !== (occ == DEPTH) || empty !== (occ == 0)) begin
        viol++; $display("violation t=%0t: count=%0d full=%b empty=%b model occupancy %0d", $time, count, full, empty, occ);
      end
      if (overflow !== exp_ovf) begin
        viol++; $display("violation t=%0t: overflow=%b model %b", $time, overflow, exp_ovf);
      end
      if (overflow) ovf_seen++;
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(acc == launched && !tx_busy && !tx_start) && n < budget) begin step(); n++; end
    checks++;
    if (n >= budget) begin errors++; $display("FAIL wait_idle: still busy after %0d cycles, want idle", n); end
    step(); step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0;
    repeat (5) step();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (count !== 5'd0)    begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int l0 = launched, v0 = viol, n = 0;
    bit got = 1'b0;
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_early_start: got %b want 0", tx_start); end
    step();
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", tx_start); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data: got %h want a5", tx_data); end
    step();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b want 0", tx_start); end
    while (!got && n < 20) begin
      if (rx_valid) got = 1'b1; else begin step(); n++; end
    end
    checks++; if (!got || rx_data !== 8'hA5) begin errors++; $display("FAIL single_loopback: valid=%b data=%h want a5", got, rx_data); end
    wait_idle(50);
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL single_drained: empty=%b count=%0d want 1/0", empty, count); end
    checks++; if (launched - l0 != 1 || viol != v0) begin errors++; $display("FAIL single_frames: frames=%0d violations=%0d want 1/0", launched - l0, viol - v0); end
  endtask

  task automatic test_burst();
    int l0 = launched, v0 = viol, peak = 0;
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      if (int'(count) > peak) peak = int'(count);
    end
    wr_en = 1'b0;
    wait_idle(200);
    checks++; if (launched - l0 != 4) begin errors++; $display("FAIL burst_frames: got %0d want 4", launched - l0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sent_log[(l0 + i) % 1024] !== 8'(i + 1)) begin
        errors++; $display("FAIL burst_order[%0d]: got %h want %h", i, sent_log[(l0 + i) % 1024], 8'(i + 1));
      end
    end
    checks++; if (peak < 3 || peak > 4) begin errors++; $display("FAIL burst_peak: got %0d want 3..4", peak); end
    checks++; if (viol != v0) begin errors++; $display("FAIL burst_protocol: %0d violations want 0", viol - v0); end
  endtask

  task automatic test_overflow();
    int l0, v0, o0;
    busy_force = 1'b1;
    step();
    l0 = launched; v0 = viol; o0 = ovf_seen;
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_en = 1'b1; wr_data = 8'(16 + i);
      step();
      if (i == DEPTH - 2) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_not_full_early: got %b want 0", full); end
      end
      if (i == DEPTH - 1) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full_at_depth: got %b want 1", full); end
      end
    end
    wr_en = 1'b0;
    step();
    checks++; if (count !== 5'(DEPTH) || full !== 1'b1) begin errors++; $display("FAIL ovf_count: count=%0d full=%b want %0d/1", count, full, DEPTH); end
    checks++; if (ovf_seen - o0 != 2) begin errors++; $display("FAIL ovf_pulses: got %0d want 2", ovf_seen - o0); end
    checks++; if (launched != l0) begin errors++; $display("FAIL ovf_no_pop_while_busy: got %0d frames want 0", launched - l0); end
    busy_force = 1'b0;
    wait_idle(400);
    checks++; if (launched - l0 != DEPTH) begin errors++; $display("FAIL ovf_drained: got %0d frames want %0d", launched - l0, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (sent_log[(l0 + i) % 1024] !== 8'(16 + i)) begin
        errors++; $display("FAIL ovf_order[%0d]: got %h want %h", i, sent_log[(l0 + i) % 1024], 8'(16 + i));
      end
    end
    checks++; if (viol != v0) begin errors++; $display("FAIL ovf_protocol: %0d violations want 0", viol - v0); end
  endtask

  task automatic test_wrap();
    int l0 = launched, v0 = viol, a0 = acc, n = 0, cyc = 0, peak = 0;
    logic [7:0] data [40];
    while (n < 40 && cyc < 3000) begin
      if ($urandom_range(0, 3) != 0 && (acc - launched) < DEPTH) begin
        data[n] = 8'($urandom); wr_en = 1'b1; wr_data = data[n]; n++;
      end else wr_en = 1'b0;
      step(); cyc++;
      if (int'(count) > peak) peak = int'(count);
    end
    wr_en = 1'b0;
    wait_idle(600);
    checks++; if (acc - a0 != 40 || launched - l0 != 40) begin errors++; $display("FAIL wrap_frames: accepted=%0d sent=%0d want 40/40", acc - a0, launched - l0); end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (sent_log[(l0 + i) % 1024] !== data[i]) begin
        errors++; $display("FAIL wrap_order[%0d]: got %h want %h", i, sent_log[(l0 + i) % 1024], data[i]);
      end
    end
    checks++; if (peak > DEPTH) begin errors++; $display("FAIL wrap_peak: got %0d want <= %0d", peak, DEPTH); end
    checks++; if (viol != v0) begin errors++; $display("FAIL wrap_protocol: %0d violations want 0", viol - v0); end
  endtask

  task automatic test_simul();
    int n = 0;
    busy_force = 1'b1;
    wr_en = 1'b1; wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    step();
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL simul_setup_count: got %0d want 1", count); end
    busy_force = 1'b0;
    wr_en = 1'b1; wr_data = 8'hC3;
    step();
    wr_en = 1'b0;
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL simul_count: got %0d want 1", count); end
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h3C) begin errors++; $display("FAIL simul_first: start=%b data=%h want 1/3c", tx_start, tx_data); end
    step();
    while (!tx_start && n < 40) begin step(); n++; end
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'hC3) begin errors++; $display("FAIL simul_next: start=%b data=%h want 1/c3", tx_start, tx_data); end
    wait_idle(100);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit started = 1'b0;
    for (int i = 0; i < 5; i++) begin wr_en = 1'b1; wr_data = 8'(8'h50 + i); step(); end
    wr_en = 1'b0;
    while (!tx_busy && n < 40) begin step(); n++; end
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL midrst_flags: count=%0d empty=%b want 0/1", count, empty); end
    checks++; if (tx_start !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL midrst_outputs: start=%b full=%b want 0/0", tx_start, full); end
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin step(); if (tx_start) started = 1'b1; end
    checks++; if (started || launched != 0) begin errors++; $display("FAIL midrst_quiet: start seen=%b frames=%0d want 0/0", started, launched); end
    wr_en = 1'b1; wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    wait_idle(60);
    checks++; if (launched != 1 || sent_log[0] !== 8'h77) begin errors++; $display("FAIL midrst_resume: frames=%0d byte=%h want 1/77", launched, sent_log[0]); end
    checks++; if (viol != 0) begin errors++; $display("FAIL protocol_total: %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_simul();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
